// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the command master and its neighbours.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte = 3'b000,
    SizeHalf = 3'b001,
    SizeWord = 3'b010
  } hsize_e;

  localparam logic [2:0] HburstSingle = 3'b000;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

  // Master-side view of the two-cycle AHB error response.
  typedef enum logic {
    ErrNone,
    ErrCancel
  } err_state_e;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command/response channel plus AHB-Lite master bus of ahb_cmd_master.
interface ahb_cmd_master_if #(
  parameter int unsigned AWIDTH = 10
);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [AWIDTH-1:0] CMD_ADDR;
  logic [2:0]        CMD_SIZE;
  logic [31:0]       CMD_WDATA;

  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERROR;
  logic              BUSY;

  logic              HSEL;
  logic [1:0]        HTRANS;
  logic [AWIDTH-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HMASTLOCK;
  logic [3:0]        HPROT;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR, BUSY,
    output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR, BUSY,
    input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_cmd_master.sv
// Single-transfer AHB-Lite master: turns one command per handshake into a pipelined
// NONSEQ transfer and returns one in-order response per command.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned AWIDTH    = 10,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_cmd_master_if.master bus
);

  // Address-phase register
  logic              a_valid_q, a_valid_d;
  logic [AWIDTH-1:0] a_addr_q, a_addr_d;
  logic              a_write_q, a_write_d;
  logic [2:0]        a_size_q, a_size_d;
  logic [31:0]       a_wdata_q, a_wdata_d;

  // Data-phase register
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [31:0]       hwdata_q, hwdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  err_state_e        err_state_q, err_state_d;

  logic cmd_ready;
  logic cmd_accept;
  logic a_issue;
  logic d_complete;
  logic hresp_err;

  assign hresp_err  = (bus.HRESP == RespError);
  assign cmd_ready  = !a_valid_q | (bus.HREADY & !hresp_err);
  assign cmd_accept = bus.CMD_VALID & cmd_ready;
  // A is only driven onto the bus when not cancelled by an error response.
  assign a_issue    = a_valid_q & (err_state_q == ErrNone);
  assign d_complete = bus.HREADY & d_valid_q;

  always_comb begin
    err_state_d = err_state_q;
    unique case (err_state_q)
      ErrNone: begin
        if (d_valid_q && hresp_err && !bus.HREADY) err_state_d = ErrCancel;
      end
      ErrCancel: begin
        if (bus.HREADY) err_state_d = ErrNone;
      end
      default: err_state_d = ErrNone;
    endcase
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    if (bus.HREADY) begin
      d_valid_d = a_issue;
      if (a_issue) begin
        a_valid_d = 1'b0;
        d_write_d = a_write_q;
        hwdata_d  = a_wdata_q;
      end
    end

    if (d_complete) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = d_write_q ? 32'h0 : bus.HRDATA;
      rsp_error_d = hresp_err;
    end

    if (cmd_accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = bus.CMD_ADDR;
      a_write_d = bus.CMD_WRITE;
      a_size_d  = bus.CMD_SIZE;
      a_wdata_d = bus.CMD_WDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'b000;
      a_wdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      err_state_q <= ErrNone;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_state_q <= err_state_d;
    end
  end

  // Address/control come straight from A so they hold their last value while idle.
  assign bus.CMD_READY = cmd_ready;
  assign bus.HSEL      = a_issue;
  assign bus.HTRANS    = a_issue ? TransNonseq : TransIdle;
  assign bus.HADDR     = a_addr_q;
  assign bus.HWRITE    = a_write_q;
  assign bus.HSIZE     = a_size_q;
  assign bus.HBURST    = HburstSingle;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = hwdata_q;

  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERROR = rsp_error_q;
  assign bus.BUSY      = a_valid_q | d_valid_q | rsp_valid_q;

endmodule
